spi_core_top: RTL and testbench
===============================

// Module: spi_core_top
// PURPOSE
// - Master-only SPI core. Serialises SPDR_From_user onto MOSI, samples MISO, generates SCK
//   and drives SS, all from one system clock.
// - Configured by an AVR-style control byte (SPCR_in) and a baud divider (SPIBR_in).
// - Pulses SPIF at the end of every completed 8-bit frame.
// PARAMETERS
// - none; the data width is fixed at 8.
// PORTS
// clk             input   1  system clock; all logic on its rising edge
// rst             input   1  asynchronous, active-high reset
// SPCR_in         input   8  [6]SPE enable, [5]DORD (1=LSB first), [4]MSTR, [3]CPOL, [2]CPHA;
//                            [7],[1:0] ignored
// SPIBR_in        input   8  baud divider N: SCK half-period = N+1 clk cycles
// SPDR_From_user  input   8  byte to transmit; sampled at frame start
// SS_master       input   1  user slave-select request, active low
// MISO            input   1  serial data in
// MOSI            output  1  serial data out
// SCK             output  1  serial clock
// SS              output  1  slave select to the slave, active low
// SPIF            output  1  frame-complete pulse, 1 clk wide
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, SCK=0, MOSI=0, SS=1, SPIF=0; shift/edge/divider counters cleared.
// - Enabled means SPE=1 and MSTR=1. SS = SS_master while enabled, else SS=1.
// - IDLE
//   - SCK=CPOL (live SPCR_in[3]), MOSI=0, SPIF=0.
//   - Goes to LOAD when enabled and SS_master=0.
// - LOAD (1 cycle)
//   - Latch CPOL, CPHA, DORD, N and shift_reg<=SPDR_From_user; clear divider and edge count.
//   - If CPHA=0, MOSI<=first bit: bit7 if DORD=0, bit0 if DORD=1.
// - XFER
//   - Divider counts 0..N; at N it wraps and SCK toggles (one edge).
//   - 16 edges per frame; odd edges are leading, even edges are trailing.
//   - CPHA=0: leading edge samples MISO; trailing edge shifts and drives the next bit (none after edge 16).
//   - CPHA=1: leading edge shifts out the next bit (first bit on edge 1); trailing edge samples MISO.
//   - Received bits enter the shift register at the end vacated by the shifted-out bit.
//   - After edge 16, go to DONE.
// - DONE (1 cycle)
//   - SPIF=1, SCK=CPOL, then IDLE.
//   - IDLE re-evaluates start, so back-to-back frames have a 1-cycle IDLE gap.
//   - Each new frame reloads SPDR_From_user.
// - Frame length: 1 (LOAD) + 16*(N+1) (XFER) + 1 (DONE) clk cycles. N=0 gives SCK=clk/2; N=255 is legal.
// - Latched configuration holds for the whole frame; SPCR_in/SPIBR_in/SPDR_From_user changes mid-frame
//   take effect at the next LOAD.
// - Abort: SS_master=1, SPE=0 or MSTR=0 during LOAD/XFER means next cycle IDLE, SCK=CPOL, MOSI=0, no SPIF.
// - Reset mid-frame: immediate reset values, no SPIF.
// - MISO is sampled synchronously on the clk edge that produces the SCK edge; X on MISO only pollutes
//   the internal shift register.
// TESTING
// - Reset: rst=1 -> SCK=0, MOSI=0, SS=1, SPIF=0; then rst=0 with SPCR_in=0x10 (SPE=0) -> no SCK activity,
//   SS=1.
// - Mode 0, MSB first: SPCR_in=0x50, SPIBR_in=2, SPDR=0xAA, SS_master=0, MISO=0 ->
//   SS=0; SCK period 60 ns (6 clk); MOSI 1,0,1,0,1,0,1,0 stable at each rising SCK;
//   SPIF 1-clk pulse 50 cycles after LOAD; next frame starts 1 IDLE cycle later.
// - Data change: after frame 1 set SPDR=0xFF -> following frame drives MOSI=1 for all 8 bits.
// - LSB first, mode 3: SPCR_in=0x7C, SPIBR_in=0, SPDR=0x01 -> SCK idles 1, period 2 clk;
//   MOSI 1,0,0,0,0,0,0,0 sampled on SCK rising edges; SPIF after 18 cycles.
// - Abort: raise SS_master after 3 SCK edges -> SS=1, SCK returns to CPOL next cycle, SPIF never pulses.
// - SPIBR_in=255 -> half-period 256 clk, frame 4098 cycles, SPIF once.

Source files
------------

// File: rtl/spi_core_top_if.sv
// Signal bundle between the SPI master core and its user/slave side.
// The core drives the serial outputs and reads config, data and MISO.
`timescale 1ns/1ps
interface spi_core_top_if;
    logic [7:0] SPCR_in;
    logic [7:0] SPIBR_in;
    logic [7:0] SPDR_From_user;
    logic       SS_master;
    logic       MISO;
    logic       MOSI;
    logic       SCK;
    logic       SS;
    logic       SPIF;

    modport master (
        input  SPCR_in,
        input  SPIBR_in,
        input  SPDR_From_user,
        input  SS_master,
        input  MISO,
        output MOSI,
        output SCK,
        output SS,
        output SPIF
    );

    modport slave (
        output SPCR_in,
        output SPIBR_in,
        output SPDR_From_user,
        output SS_master,
        output MISO,
        input  MOSI,
        input  SCK,
        input  SS,
        input  SPIF
    );
endinterface

// File: rtl/spi_core_top.sv
// Master-only 8-bit SPI core with AVR-style control byte.
// One frame: LOAD, 16 SCK edges of N+1 clk each, DONE with SPIF.
`timescale 1ns/1ps
module spi_core_top (
    input logic          clk,
    input logic          rst,
    spi_core_top_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        XFER,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] shift_reg;
    logic [7:0] div_cnt;
    logic [7:0] n_q;
    logic [3:0] edge_cnt;
    logic       cpol_q;
    logic       cpha_q;
    logic       dord_q;
    logic       miso_q;
    logic       sck_q;
    logic       mosi_q;
    logic       ss_q;
    logic       spif_q;

    logic       enabled;
    logic       go;
    logic       last_div;
    logic       leading;
    logic       last_edge;
    logic       fill;
    logic       out_bit;
    logic       next_bit;
    logic [7:0] shifted;
    logic       unused_cfg;

    assign enabled   = bus.SPCR_in[6] & bus.SPCR_in[4];
    assign go        = enabled & ~bus.SS_master;
    assign last_div  = (div_cnt == n_q);
    // edge_cnt holds completed edges, so an even count means the
    // upcoming edge is a leading (odd-numbered) one.
    assign leading   = ~edge_cnt[0];
    assign last_edge = (edge_cnt == 4'd15);
    // CPHA=0 captured MISO on the leading edge; CPHA=1 takes it live.
    assign fill      = cpha_q ? bus.MISO : miso_q;
    assign out_bit   = dord_q ? shift_reg[0] : shift_reg[7];
    assign next_bit  = dord_q ? shift_reg[1] : shift_reg[6];
    assign shifted   = dord_q ? {fill, shift_reg[7:1]}
                              : {shift_reg[6:0], fill};
    assign unused_cfg = ^{bus.SPCR_in[7], bus.SPCR_in[1:0]};

    assign bus.SCK  = sck_q;
    assign bus.MOSI = mosi_q;
    assign bus.SS   = ss_q;
    assign bus.SPIF = spif_q;

    // Slave select follows the user request only while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q <= 1'b1;
        end else begin
            ss_q <= enabled ? bus.SS_master : 1'b1;
        end
    end

    // Frame sequencer: config latch, baud divider, SCK edges, shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= 8'h00;
            div_cnt   <= 8'h00;
            n_q       <= 8'h00;
            edge_cnt  <= 4'd0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            dord_q    <= 1'b0;
            miso_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            spif_q    <= 1'b0;
        end else begin
            spif_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    sck_q  <= bus.SPCR_in[3];
                    mosi_q <= 1'b0;
                    if (go) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    sck_q <= bus.SPCR_in[3];
                    if (!go) begin
                        state  <= IDLE;
                        mosi_q <= 1'b0;
                    end else begin
                        state     <= XFER;
                        cpol_q    <= bus.SPCR_in[3];
                        cpha_q    <= bus.SPCR_in[2];
                        dord_q    <= bus.SPCR_in[5];
                        n_q       <= bus.SPIBR_in;
                        shift_reg <= bus.SPDR_From_user;
                        div_cnt   <= 8'h00;
                        edge_cnt  <= 4'd0;
                        if (!bus.SPCR_in[2]) begin
                            mosi_q <= bus.SPCR_in[5]
                                    ? bus.SPDR_From_user[0]
                                    : bus.SPDR_From_user[7];
                        end
                    end
                end
                XFER: begin
                    if (!go) begin
                        state  <= IDLE;
                        sck_q  <= cpol_q;
                        mosi_q <= 1'b0;
                    end else if (last_div) begin
                        div_cnt  <= 8'h00;
                        sck_q    <= ~sck_q;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (leading) begin
                            if (cpha_q) begin
                                mosi_q <= out_bit;
                            end else begin
                                miso_q <= bus.MISO;
                            end
                        end else begin
                            shift_reg <= shifted;
                            if (!cpha_q && !last_edge) begin
                                mosi_q <= next_bit;
                            end
                        end
                        if (last_edge) begin
                            state  <= DONE;
                            spif_q <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    sck_q <= cpol_q;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_core_top.sv
// Bench for spi_core_top: directed and random frames checked
// against a slave-side view of SPI timing and bit order.
`timescale 1ns/1ps
module tb_spi_core_top;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    spi_core_top_if bus();

    spi_core_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame as a slave would see it. b2b: called at the SPIF
    // cycle of a previous frame with SS_master still low. stay: leave
    // SS_master low on return so the next frame follows at once.
    task automatic frame(input logic [7:0] spcr,
                         input logic [7:0] n,
                         input logic [7:0] data,
                         input bit b2b,
                         input bit stay,
                         input string tag);
        logic       cpol, cpha, dord, samp_lvl, prev_sck, mb;
        logic [7:0] rx;
        int         cyc, toggles, first_t, last_t, bad_iv;
        int         nbits, spif_cyc, spif_n, budget, half;
        logic       ss_at, sck_at;
        cpol     = spcr[3];
        cpha     = spcr[2];
        dord     = spcr[5];
        samp_lvl = ~(cpol ^ cpha);
        half     = int'(n) + 1;
        budget   = 16 * half + 40;
        bus.SPCR_in        = spcr;
        bus.SPIBR_in       = n;
        bus.SPDR_From_user = data;
        if (!b2b) begin
            bus.SS_master = 1'b1;
            @(negedge clk);
            chk({tag, "_idle_sck"}, bus.SCK, cpol);
            bus.SS_master = 1'b0;
        end
        rx = 8'h00;
        cyc = 0; toggles = 0; first_t = -1; last_t = 0;
        bad_iv = 0; nbits = 0; spif_cyc = -1; spif_n = 0;
        ss_at = 1'bx; sck_at = 1'bx;
        prev_sck = bus.SCK;
        while (spif_n == 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.MISO = 1'($urandom_range(0, 1));
            if (bus.SCK !== prev_sck) begin
                toggles++;
                if (toggles == 1) first_t = cyc;
                else if (cyc - last_t != half) bad_iv++;
                last_t = cyc;
                if (bus.SCK === samp_lvl && nbits < 8) begin
                    mb = bus.MOSI;
                    rx[dord ? nbits : 7 - nbits] = mb;
                    nbits++;
                end
            end
            prev_sck = bus.SCK;
            if (bus.SPIF === 1'b1) begin
                spif_n++;
                spif_cyc = cyc;
                ss_at = bus.SS;
                sck_at = bus.SCK;
            end
        end
        chk({tag, "_spif_seen"}, spif_n, 1);
        chk({tag, "_latency"}, spif_cyc,
            16 * half + 2 + (b2b ? 1 : 0));
        chk({tag, "_edges"}, toggles, 16);
        chk({tag, "_first_edge"}, first_t,
            half + 2 + (b2b ? 1 : 0));
        chk({tag, "_half_period"}, bad_iv, 0);
        chk({tag, "_nbits"}, nbits, 8);
        chk({tag, "_data"}, rx, data);
        chk({tag, "_ss_low"}, ss_at, 1'b0);
        chk({tag, "_done_sck"}, sck_at, cpol);
        if (!stay) begin
            @(negedge clk);
            chk({tag, "_spif_width"}, bus.SPIF, 1'b0);
            bus.SS_master = 1'b1;
        end
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c;
        logic [7:0] spcr, n, d;

        rst = 1'b1;
        bus.SPCR_in        = 8'h10;
        bus.SPIBR_in       = 8'h00;
        bus.SPDR_From_user = 8'h00;
        bus.SS_master      = 1'b1;
        bus.MISO           = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck", bus.SCK, 1'b0);
        chk("rst_mosi", bus.MOSI, 1'b0);
        chk("rst_ss", bus.SS, 1'b1);
        chk("rst_spif", bus.SPIF, 1'b0);

        // Disabled core ignores a slave-select request.
        rst = 1'b0;
        bus.SS_master = 1'b0;
        cnt_a = 0; cnt_b = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.SCK !== 1'b0) cnt_a++;
            if (bus.SS !== 1'b1) cnt_b++;
        end
        chk("dis_sck_quiet", cnt_a, 0);
        chk("dis_ss_high", cnt_b, 0);
        bus.SS_master = 1'b1;

        // Mode 0 MSB first, then a back-to-back frame with new data.
        frame(8'h50, 8'd2, 8'hAA, 1'b0, 1'b1, "m0");
        frame(8'h50, 8'd2, 8'hFF, 1'b1, 1'b0, "m0b2b");

        // Mode 3 LSB first at the fastest baud.
        frame(8'h7C, 8'd0, 8'h01, 1'b0, 1'b0, "m3lsb");

        // Random modes, dividers, data and ignored control bits.
        for (int i = 0; i < 8; i++) begin
            spcr = (8'($urandom_range(0, 255)) & 8'hAF) | 8'h50;
            n    = 8'($urandom_range(0, 6));
            d    = 8'($urandom_range(0, 255));
            frame(spcr, n, d, 1'b0, 1'b0, "rnd");
        end

        // Abort after three SCK edges in mode 2.
        bus.SPCR_in  = 8'h58;
        bus.SPIBR_in = 8'd1;
        bus.SPDR_From_user = 8'($urandom_range(0, 255));
        @(negedge clk);
        bus.SS_master = 1'b0;
        cnt_a = 0; cnt_b = 0;
        cnt_c = bus.SCK;
        while (cnt_a < 3 && cnt_b < 60) begin
            @(negedge clk);
            cnt_b++;
            if (bus.SCK !== 1'(cnt_c)) cnt_a++;
            cnt_c = bus.SCK;
        end
        chk("ab_edges", cnt_a, 3);
        bus.SS_master = 1'b1;
        @(negedge clk);
        chk("ab_ss", bus.SS, 1'b1);
        chk("ab_sck", bus.SCK, 1'b1);
        chk("ab_mosi", bus.MOSI, 1'b0);
        cnt_a = 0; cnt_b = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.SPIF !== 1'b0) cnt_a++;
            if (bus.SCK !== 1'b1) cnt_b++;
        end
        chk("ab_no_spif", cnt_a, 0);
        chk("ab_sck_idle", cnt_b, 0);

        // Reset in the middle of a frame.
        bus.SPCR_in  = 8'h50;
        bus.SPIBR_in = 8'd3;
        bus.SS_master = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_sck", bus.SCK, 1'b0);
        chk("mrst_mosi", bus.MOSI, 1'b0);
        chk("mrst_ss", bus.SS, 1'b1);
        chk("mrst_spif", bus.SPIF, 1'b0);
        bus.SS_master = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame(8'h50, 8'd1, 8'($urandom_range(0, 255)),
              1'b0, 1'b0, "post_rst");

        // Slowest divider.
        frame(8'h54, 8'd255, 8'($urandom_range(0, 255)),
              1'b0, 1'b0, "n255");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
